mii_frame_tx: RTL

//  Transmit side of the 1.6T MII-style word link: packs payload words from a valid/ready

---
 rtl/mii_pkg.sv | 70 +++++++
 rtl/mii_ipg_timer.sv | 42 ++++
 rtl/mii_frame_tx.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/mii_pkg.sv
// ----------------------------------------------------------------------------
// mii_pkg
//   Shared definitions for the MII-style word link. Both the transmit framer
//   and generator_checker import this package.
//   Contents:
//     - control code bytes: IDLE_CODE, START_CODE, EOF_CODE, ERR_CODE
//     - mii_tx_state_t : transmit framer FSM states
//     - mii_w_idle / mii_w_start / mii_w_eof / mii_w_err : build a control
//       word for NB byte lanes. Each returns an MII_MAX_W-bit vector. Only the
//       low NB*8 bits are meaningful, so the caller slices off its own width.
// ----------------------------------------------------------------------------
package mii_pkg;

    localparam logic [7:0] IDLE_CODE  = 8'h07;
    localparam logic [7:0] START_CODE = 8'hFB;
    localparam logic [7:0] EOF_CODE   = 8'hFD;
    localparam logic [7:0] ERR_CODE   = 8'hFE;

    // Widest link word the word builders support.
    localparam int MII_MAX_W = 2048;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        DRAIN,
        EOF
    } mii_tx_state_t;

    // Fill every lane below nb with the same code byte.
    function automatic logic [MII_MAX_W-1:0] mii_fill(input int nb, input logic [7:0] code);
        logic [MII_MAX_W-1:0] w;
        w = '0;
        for (int i = 0; i < MII_MAX_W / 8; i++) begin
            if (i < nb) begin
                w[i*8 +: 8] = code;
            end
        end
        return w;
    endfunction

    function automatic logic [MII_MAX_W-1:0] mii_w_idle(input int nb);
        return mii_fill(nb, IDLE_CODE);
    endfunction

    // START sits in byte 0; the other lanes carry IDLE.
    function automatic logic [MII_MAX_W-1:0] mii_w_start(input int nb);
        logic [MII_MAX_W-1:0] w;
        w       = mii_fill(nb, IDLE_CODE);
        w[7:0]  = START_CODE;
        return w;
    endfunction

    // EOF sits in the top lane; the lanes below it carry IDLE.
    function automatic logic [MII_MAX_W-1:0] mii_w_eof(input int nb);
        logic [MII_MAX_W-1:0] w;
        w = mii_fill(nb, IDLE_CODE);
        for (int i = 0; i < MII_MAX_W / 8; i++) begin
            if (i == nb - 1) begin
                w[i*8 +: 8] = EOF_CODE;
            end
        end
        return w;
    endfunction

    function automatic logic [MII_MAX_W-1:0] mii_w_err(input int nb);
        return mii_fill(nb, ERR_CODE);
    endfunction

endpackage

// File: rtl/mii_ipg_timer.sv
// ----------------------------------------------------------------------------
// mii_ipg_timer
//   Saturating inter-frame gap counter. It counts enabled cycles up to
//   IPG_WORDS and then holds there. gap_done is high once IPG_WORDS cycles
//   have been counted since the last clear.
//   Ports:
//     clk       in   clock
//     i_rst     in   asynchronous active-high reset (count = 0)
//     clear     in   synchronous clear to 0 (has priority over enable)
//     enable    in   count one gap cycle
//     gap_done  out  count has reached IPG_WORDS
// ----------------------------------------------------------------------------
module mii_ipg_timer #(
    parameter int IPG_WORDS = 1
) (
    input  logic clk,
    input  logic i_rst,
    input  logic clear,
    input  logic enable,
    output logic gap_done
);

    localparam int CW = $clog2(IPG_WORDS + 1);
    localparam logic [CW-1:0] GAP_MAX = CW'(IPG_WORDS);

    logic [CW-1:0] gap_cnt;

    // NOTE: sequential state is written with non-blocking assignments only, so
    // every flop samples the values that were present before the clock edge.
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            gap_cnt <= '0;
        end else if (clear) begin
            gap_cnt <= '0;
        end else if (enable && (gap_cnt != GAP_MAX)) begin
            gap_cnt <= gap_cnt + 1'b1;
        end
    end

    assign gap_done = (gap_cnt >= GAP_MAX);

endmodule

// File: rtl/mii_frame_tx.sv
// ----------------------------------------------------------------------------
// mii_frame_tx
//   Transmit framer for the MII-style word link. It takes payload words from a
//   valid/ready stream and wraps each frame as START, DATA..., EOF control-coded
//   link words. It holds at least IPG_WORDS IDLE words between frames. If the
//   source underruns mid-frame (valid drops), the frame is aborted with a single
//   ERROR word and the rest of that frame is discarded.
//
//   Parameters:
//     DATA_WIDTH  link word width in bits (a multiple of 8)
//     IPG_WORDS   minimum number of IDLE words between EOF and the next START
//
//   Ports:
//     clk          in   clock
//     i_rst        in   asynchronous active-high reset
//     i_data       in   payload word
//     i_valid      in   i_data valid
//     i_last       in   final payload word of the frame
//     o_ready      out  payload word accepted when i_valid & o_ready
//     o_tx_data    out  link word (registered)
//     o_tx_ctrl    out  1 = control word, 0 = payload word (registered)
//     o_frame_cnt  out  frames completed with EOF   (MII_TX_STATS_EN only)
//     o_abort_cnt  out  frames aborted on underrun  (MII_TX_STATS_EN only)
//
//   Build option: define MII_TX_STATS_EN to add the two wrapping 16-bit
//   statistics counters and their ports.
//
//   Timing: the state register selects the word that is loaded into the
//   output register. A word decided in state S is therefore seen on the link
//   one cycle later. An accepted payload word is on o_tx_data exactly one
//   cycle after its handshake.
// ----------------------------------------------------------------------------
module mii_frame_tx
    import mii_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int IPG_WORDS  = 1
) (
    input  logic                  clk,
    input  logic                  i_rst,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_valid,
    input  logic                  i_last,
    output logic                  o_ready,
    output logic [DATA_WIDTH-1:0] o_tx_data,
    output logic                  o_tx_ctrl
`ifdef MII_TX_STATS_EN
   ,output logic [15:0]           o_frame_cnt,
    output logic [15:0]           o_abort_cnt
`endif
);

    localparam int NB = DATA_WIDTH / 8;

    localparam logic [MII_MAX_W-1:0] W_IDLE_FULL  = mii_w_idle(NB);
    localparam logic [MII_MAX_W-1:0] W_START_FULL = mii_w_start(NB);
    localparam logic [MII_MAX_W-1:0] W_EOF_FULL   = mii_w_eof(NB);
    localparam logic [MII_MAX_W-1:0] W_ERR_FULL   = mii_w_err(NB);

    localparam logic [DATA_WIDTH-1:0] W_IDLE  = W_IDLE_FULL[DATA_WIDTH-1:0];
    localparam logic [DATA_WIDTH-1:0] W_START = W_START_FULL[DATA_WIDTH-1:0];
    localparam logic [DATA_WIDTH-1:0] W_EOF   = W_EOF_FULL[DATA_WIDTH-1:0];
    localparam logic [DATA_WIDTH-1:0] W_ERR   = W_ERR_FULL[DATA_WIDTH-1:0];

    mii_tx_state_t         state, state_nxt;
    logic [DATA_WIDTH-1:0] tx_data_nxt;
    logic                  tx_ctrl_nxt;
    logic                  gap_done;
    logic                  load_eof;
    logic                  load_err;

    // The gap count restarts whenever the link leaves IDLE. It only begins
    // counting once the framer is back in IDLE, which is after the EOF or the
    // drained abort.
    mii_ipg_timer #(
        .IPG_WORDS (IPG_WORDS)
    ) u_ipg_timer (
        .clk      (clk),
        .i_rst    (i_rst),
        .clear    (state != IDLE),
        .enable   (state == IDLE),
        .gap_done (gap_done)
    );

    // Ready is decoded straight from the registered state, so it is glitch-free
    // and does not depend combinationally on i_valid.
    assign o_ready = (state == START) || (state == DATA) || (state == DRAIN);

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every output of this block gets a default before the case
    // statement, so no path can leave a signal unassigned and infer a latch.
    always_comb begin
        state_nxt   = state;
        tx_data_nxt = W_IDLE;
        tx_ctrl_nxt = 1'b1;
        load_eof    = 1'b0;
        load_err    = 1'b0;

        unique case (state)
            IDLE: begin
                if (i_valid && gap_done) begin
                    state_nxt   = START;
                    tx_data_nxt = W_START;
                end
            end

            // W_START is on the link while the first beat is accepted, so
            // START and DATA handle a beat in the same way.
            START, DATA: begin
                if (i_valid) begin
                    tx_data_nxt = i_data;
                    tx_ctrl_nxt = 1'b0;
                    state_nxt   = i_last ? EOF : DATA;
                end else begin
                    tx_data_nxt = W_ERR;
                    load_err    = 1'b1;
                    state_nxt   = DRAIN;
                end
            end

            // Beats of the aborted frame are accepted but never reach the link.
            DRAIN: begin
                if (i_valid && i_last) begin
                    state_nxt = IDLE;
                end
            end

            EOF: begin
                tx_data_nxt = W_EOF;
                load_eof    = 1'b1;
                state_nxt   = IDLE;
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            o_tx_data <= W_IDLE;
            o_tx_ctrl <= 1'b1;
        end else begin
            o_tx_data <= tx_data_nxt;
            o_tx_ctrl <= tx_ctrl_nxt;
        end
    end

`ifdef MII_TX_STATS_EN
    // The counters advance on the same edge that loads the EOF or ERROR word,
    // and they wrap naturally at 16 bits.
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            o_frame_cnt <= '0;
            o_abort_cnt <= '0;
        end else begin
            if (load_eof) begin
                o_frame_cnt <= o_frame_cnt + 16'd1;
            end
            if (load_err) begin
                o_abort_cnt <= o_abort_cnt + 16'd1;
            end
        end
    end
`endif

endmodule
